// File: rtl/sap_pkg.sv
// Shared definitions for the SAP control sequencer: opcodes, control-word bit
// positions, the inactive control word and the RUN/HALTED state encoding.
package sap_pkg;

  localparam int OP_LDA = 0;
  localparam int OP_ADD = 1;
  localparam int OP_SUB = 2;
  localparam int OP_JMP = 3;
  localparam int OP_JZ  = 4;
  localparam int OP_OUT = 14;
  localparam int OP_HLT = 15;

  localparam int CW_W  = 13;
  localparam int CW_CP = 12;
  localparam int CW_EP = 11;
  localparam int CW_LM = 10;
  localparam int CW_CE = 9;
  localparam int CW_LI = 8;
  localparam int CW_EI = 7;
  localparam int CW_LA = 6;
  localparam int CW_EA = 5;
  localparam int CW_SU = 4;
  localparam int CW_EU = 3;
  localparam int CW_LB = 2;
  localparam int CW_LO = 1;
  localparam int CW_LP = 0;

  // Active-low strobes idle high, everything else idles low.
  localparam logic [CW_W-1:0] CW_IDLE = 13'h07C6;

  typedef enum logic {
    SEQ_RUN    = 1'b0,
    SEQ_HALTED = 1'b1
  } seq_state_e;

  // Drive one control signal to its active level, whatever its polarity.
  function automatic logic [CW_W-1:0] cw_on(input logic [CW_W-1:0] cw, input int idx);
    logic [CW_W-1:0] r;
    r      = cw;
    r[idx] = ~CW_IDLE[idx];
    return r;
  endfunction

endpackage

// File: rtl/ring_counter.sv
// One-hot ring counter: synchronous clear to bit0, rotates left when enabled
// and not held.
module ring_counter #(
  parameter int N = 6
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic         hold,
  output logic [N-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= N'(1);
    end else if (en && !hold) begin
      q <= {q[N-2:0], q[N-1]};
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// SAP control sequencer: T-state ring plus RUN/HALTED machine with a
// zero-latency control-word decode. Define SEQ_JUMP_EN to decode JMP and JZ.
module control_sequencer
  import sap_pkg::*;
#(
  parameter int OP_W     = 4,
  parameter int T_STATES = 6
) (
  input  logic                clk,
  input  logic                low_clr,
  input  logic                en,
  input  logic [OP_W-1:0]     op_code,
  input  logic                zero_flag,
  output logic [T_STATES-1:0] t_state,
  output logic [CW_W-1:0]     ctrl,
  output logic                low_halt
);

  localparam logic [OP_W-1:0] C_LDA = OP_W'(OP_LDA);
  localparam logic [OP_W-1:0] C_ADD = OP_W'(OP_ADD);
  localparam logic [OP_W-1:0] C_SUB = OP_W'(OP_SUB);
  localparam logic [OP_W-1:0] C_OUT = OP_W'(OP_OUT);
  localparam logic [OP_W-1:0] C_HLT = OP_W'(OP_HLT);
`ifdef SEQ_JUMP_EN
  localparam logic [OP_W-1:0] C_JMP = OP_W'(OP_JMP);
  localparam logic [OP_W-1:0] C_JZ  = OP_W'(OP_JZ);
`else
  logic unused_zero_flag;
  assign unused_zero_flag = zero_flag;
`endif

  seq_state_e      state_q;
  seq_state_e      state_d;
  logic            halt_now;
  logic            ring_hold;
  logic [CW_W-1:0] cw;

  // HLT seen in T4 halts the ring on the same edge that latches HALTED.
  assign halt_now  = (state_q == SEQ_RUN) && t_state[3] && (op_code == C_HLT);
  assign ring_hold = (state_q == SEQ_HALTED) || halt_now;

  ring_counter #(
    .N (T_STATES)
  ) u_ring (
    .clk  (clk),
    .clr  (!low_clr),
    .en   (en),
    .hold (ring_hold),
    .q    (t_state)
  );

  always_ff @(posedge clk) begin
    if (!low_clr) begin
      state_q <= SEQ_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (halt_now && en) begin
      state_d = SEQ_HALTED;
    end
  end

  always_comb begin
    cw       = CW_IDLE;
    low_halt = 1'b1;
    if (low_clr) begin
      if ((state_q == SEQ_HALTED) || halt_now) begin
        low_halt = 1'b0;
      end
      if (en && (state_q == SEQ_RUN)) begin
        if (t_state[0]) cw = cw_on(cw_on(cw, CW_EP), CW_LM);
        if (t_state[1]) cw = cw_on(cw, CW_CP);
        if (t_state[2]) cw = cw_on(cw_on(cw, CW_CE), CW_LI);
        if (t_state[3]) begin
          case (op_code)
            C_LDA, C_ADD, C_SUB: cw = cw_on(cw_on(cw, CW_LM), CW_EI);
            C_OUT:               cw = cw_on(cw_on(cw, CW_EA), CW_LO);
`ifdef SEQ_JUMP_EN
            C_JMP:               cw = cw_on(cw_on(cw, CW_EI), CW_LP);
            C_JZ: begin
              if (zero_flag) cw = cw_on(cw_on(cw, CW_EI), CW_LP);
            end
`endif
            default: ;
          endcase
        end
        if (t_state[4]) begin
          case (op_code)
            C_LDA:        cw = cw_on(cw_on(cw, CW_CE), CW_LA);
            C_ADD, C_SUB: cw = cw_on(cw_on(cw, CW_CE), CW_LB);
            default: ;
          endcase
        end
        if (t_state[5]) begin
          case (op_code)
            C_ADD:   cw = cw_on(cw_on(cw, CW_EU), CW_LA);
            C_SUB:   cw = cw_on(cw_on(cw_on(cw, CW_EU), CW_SU), CW_LA);
            default: ;
          endcase
        end
      end
    end
  end

  assign ctrl = cw;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer (6-state and 8-state rings);
// expected control words come from a hex table built from the bit map.
module tb_control_sequencer;

  localparam bit JMP_EN =
`ifdef SEQ_JUMP_EN
    1'b1;
`else
    1'b0;
`endif

  logic        clk = 1'b0;
  logic        low_clr, en, zero_flag;
  logic [3:0]  op_code;
  logic [5:0]  t_state6;
  logic [12:0] ctrl6;
  logic        lh6;
  logic [7:0]  t_state8;
  logic [12:0] ctrl8;
  logic        lh8;

  always #5 clk = ~clk;

  control_sequencer #(.OP_W(4), .T_STATES(6)) dut (
    .clk(clk), .low_clr(low_clr), .en(en), .op_code(op_code), .zero_flag(zero_flag),
    .t_state(t_state6), .ctrl(ctrl6), .low_halt(lh6)
  );

  control_sequencer #(.OP_W(4), .T_STATES(8)) dut8 (
    .clk(clk), .low_clr(low_clr), .en(en), .op_code(op_code), .zero_flag(zero_flag),
    .t_state(t_state8), .ctrl(ctrl8), .low_halt(lh8)
  );

  typedef struct {
    logic [7:0]  ts;
    logic [12:0] cw;
    logic        lh;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   compares = 0;
  int   fails    = 0;
  int   tm6 = 0, tm8 = 0;
  bit   hm6 = 0, hm8 = 0;

  function automatic logic [12:0] ref_cw(input int tm, input bit hm);
    if (!low_clr || !en || hm) return 13'h07C6;
    case (tm)
      0: return 13'h0BC6;
      1: return 13'h17C6;
      2: return 13'h04C6;
      3: case (op_code)
           4'd0, 4'd1, 4'd2: return 13'h0346;
           4'd14:            return 13'h07E4;
           4'd3:             return JMP_EN ? 13'h0747 : 13'h07C6;
           4'd4:             return (JMP_EN && zero_flag) ? 13'h0747 : 13'h07C6;
           default:          return 13'h07C6;
         endcase
      4: case (op_code)
           4'd0:       return 13'h0586;
           4'd1, 4'd2: return 13'h05C2;
           default:    return 13'h07C6;
         endcase
      5: case (op_code)
           4'd1:    return 13'h078E;
           4'd2:    return 13'h079E;
           default: return 13'h07C6;
         endcase
      default: return 13'h07C6;
    endcase
  endfunction

  function automatic logic ref_lh(input int tm, input bit hm);
    if (!low_clr) return 1'b1;
    if (hm || (tm == 3 && op_code == 4'd15)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic exp_t exp_of(input int tm, input bit hm, input string name);
    exp_t e;
    e.ts   = 8'(32'd1 << tm);
    e.cw   = ref_cw(tm, hm);
    e.lh   = ref_lh(tm, hm);
    e.name = name;
    return e;
  endfunction

  // Behavioural model of one rising edge, using the inputs held in this cycle.
  function automatic void model_clock();
    if (!low_clr) begin
      tm6 = 0; hm6 = 0; tm8 = 0; hm8 = 0;
    end else if (en) begin
      if (!hm6) begin
        if (tm6 == 3 && op_code == 4'd15) hm6 = 1; else tm6 = (tm6 + 1) % 6;
      end
      if (!hm8) begin
        if (tm8 == 3 && op_code == 4'd15) hm8 = 1; else tm8 = (tm8 + 1) % 8;
      end
    end
  endfunction

  task automatic tick();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    low_clr = 0; en = 1; op_code = 4'd15; zero_flag = 0;
    tick(); tick();
    for (int i = 0; i < 2; i++) begin
      if (i == 1) low_clr = 1;
      sb.push_back(exp_of(tm6, hm6, (i == 0) ? "reset_held" : "reset_release_t1"));
      @(negedge clk);
      e = sb.pop_front();
      compares++;
      if ({t_state6, ctrl6, lh6} !== {e.ts[5:0], e.cw, e.lh}) begin
        fails++;
        $display("FAIL %s: got t_state=%h ctrl=%h low_halt=%b want %h %h %b",
                 e.name, t_state6, ctrl6, lh6, e.ts[5:0], e.cw, e.lh);
      end
      tick();
    end
  endtask

  task automatic test_fetch_lda();
    exp_t e;
    low_clr = 0; en = 1; op_code = 4'd0; zero_flag = 0;
    tick();
    low_clr = 1;
    for (int i = 0; i < 7; i++) begin
      sb.push_back(exp_of(tm6, hm6, $sformatf("lda_step%0d", i)));
      @(negedge clk);
      e = sb.pop_front();
      compares++;
      if ({t_state6, ctrl6, lh6} !== {e.ts[5:0], e.cw, e.lh}) begin
        fails++;
        $display("FAIL %s: got t_state=%h ctrl=%h low_halt=%b want %h %h %b",
                 e.name, t_state6, ctrl6, lh6, e.ts[5:0], e.cw, e.lh);
      end
      tick();
    end
  endtask

  task automatic test_hold();
    exp_t e;
    logic en_seq [9] = '{1, 0, 0, 0, 1, 1, 1, 1, 1};
    low_clr = 0; en = 1; op_code = 4'd1; zero_flag = 0;
    tick();
    low_clr = 1;
    for (int i = 0; i < 9; i++) begin
      en = en_seq[i];
      sb.push_back(exp_of(tm6, hm6, $sformatf("hold_add_step%0d", i)));
      @(negedge clk);
      e = sb.pop_front();
      compares++;
      if ({t_state6, ctrl6, lh6} !== {e.ts[5:0], e.cw, e.lh}) begin
        fails++;
        $display("FAIL %s: got t_state=%h ctrl=%h low_halt=%b want %h %h %b",
                 e.name, t_state6, ctrl6, lh6, e.ts[5:0], e.cw, e.lh);
      end
      tick();
    end
  endtask

  task automatic test_opcodes();
    exp_t e;
    logic [3:0] ops [7] = '{4'd2, 4'd14, 4'd3, 4'd4, 4'd4, 4'd7, 4'd9};
    logic       zfs [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 7; k++) begin
      low_clr = 0; en = 1; op_code = ops[k]; zero_flag = zfs[k];
      tick();
      low_clr = 1;
      for (int i = 0; i < 6; i++) begin
        sb.push_back(exp_of(tm6, hm6, $sformatf("op%0d_zf%0d_t%0d", ops[k], zfs[k], i + 1)));
        @(negedge clk);
        e = sb.pop_front();
        compares++;
        if ({t_state6, ctrl6, lh6} !== {e.ts[5:0], e.cw, e.lh}) begin
          fails++;
          $display("FAIL %s: got t_state=%h ctrl=%h low_halt=%b want %h %h %b",
                   e.name, t_state6, ctrl6, lh6, e.ts[5:0], e.cw, e.lh);
        end
        tick();
      end
    end
  endtask

  task automatic test_halt();
    exp_t e;
    logic en_seq  [14] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 1, 1};
    logic clr_seq [14] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1};
    low_clr = 0; en = 1; op_code = 4'd15; zero_flag = 0;
    tick();
    for (int i = 0; i < 14; i++) begin
      en = en_seq[i];
      low_clr = clr_seq[i];
      sb.push_back(exp_of(tm6, hm6, $sformatf("halt_step%0d", i)));
      @(negedge clk);
      e = sb.pop_front();
      compares++;
      if ({t_state6, ctrl6, lh6} !== {e.ts[5:0], e.cw, e.lh}) begin
        fails++;
        $display("FAIL %s: got t_state=%h ctrl=%h low_halt=%b want %h %h %b",
                 e.name, t_state6, ctrl6, lh6, e.ts[5:0], e.cw, e.lh);
      end
      tick();
    end
  endtask

  task automatic test_t8();
    exp_t e;
    low_clr = 0; en = 1; op_code = 4'd0; zero_flag = 0;
    tick();
    low_clr = 1;
    for (int i = 0; i < 10; i++) begin
      sb.push_back(exp_of(tm8, hm8, $sformatf("ring8_step%0d", i)));
      @(negedge clk);
      e = sb.pop_front();
      compares++;
      if ({t_state8, ctrl8, lh8} !== {e.ts, e.cw, e.lh}) begin
        fails++;
        $display("FAIL %s: got t_state=%h ctrl=%h low_halt=%b want %h %h %b",
                 e.name, t_state8, ctrl8, lh8, e.ts, e.cw, e.lh);
      end
      tick();
    end
  endtask

  initial begin
    low_clr = 0; en = 0; op_code = 4'd0; zero_flag = 0;
    test_reset();
    test_fetch_lda();
    test_hold();
    test_opcodes();
    test_halt();
    test_t8();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
